// File: rtl/aic3204_cfg_seq.sv
// rtl/aic3204_cfg_seq.sv - table-driven codec register configuration sequencer
// Optional read-back verification of WRITE entries: define AIC3204_CFG_READBACK_EN.
module aic3204_cfg_seq #(
  parameter int DELAY_UNIT = 100000,
  parameter int MAX_RETRY  = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [7:0]  tbl_addr,
  input  logic [17:0] tbl_data,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        cmd_rw,
  output logic [7:0]  cmd_reg,
  output logic [7:0]  cmd_wdata,
  input  logic        rsp_valid,
  input  logic        rsp_nack,
  input  logic [7:0]  rsp_rdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  err_addr
);

  localparam int CNT_W = $clog2(255 * DELAY_UNIT + 1);
  localparam int RTY_W = $clog2(MAX_RETRY + 2);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, ISSUE, WAIT_RSP, DELAY, DONE, ERROR
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] dly_cnt;
  logic [RTY_W-1:0] retry;
  logic             last_entry;

  assign last_entry = (tbl_addr == 8'hFF);

`ifdef AIC3204_CFG_READBACK_EN
  logic is_write;
  logic rw_q;
  assign cmd_rw = rw_q;
`else
  logic unused_rdata;
  assign unused_rdata = ^rsp_rdata;
  assign cmd_rw       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      tbl_addr  <= 8'h00;
      cmd_valid <= 1'b0;
      cmd_reg   <= 8'h00;
      cmd_wdata <= 8'h00;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_addr  <= 8'h00;
      dly_cnt   <= '0;
      retry     <= '0;
`ifdef AIC3204_CFG_READBACK_EN
      rw_q      <= 1'b0;
      is_write  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            tbl_addr <= 8'h00;
            done     <= 1'b0;
            error    <= 1'b0;
            err_addr <= 8'h00;
            retry    <= '0;
            busy     <= 1'b1;
            state    <= FETCH;
          end
        end
        FETCH: state <= DECODE;
        DECODE: begin
          cmd_wdata <= tbl_data[7:0];
`ifdef AIC3204_CFG_READBACK_EN
          rw_q     <= 1'b0;
          is_write <= (tbl_data[17:16] == 2'b00);
`endif
          case (tbl_data[17:16])
            2'b00: begin
              cmd_reg   <= tbl_data[15:8];
              cmd_valid <= 1'b1;
              state     <= ISSUE;
            end
            2'b10: begin
              cmd_reg   <= 8'h00;
              cmd_valid <= 1'b1;
              state     <= ISSUE;
            end
            2'b01: begin
              dly_cnt <= CNT_W'(tbl_data[7:0]) * CNT_W'(DELAY_UNIT);
              state   <= DELAY;
            end
            default: begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= DONE;
            end
          endcase
        end
        ISSUE: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (rsp_valid) begin
            if (rsp_nack) begin
              if (retry < RTY_W'(MAX_RETRY)) begin
                retry     <= retry + RTY_W'(1);
                cmd_valid <= 1'b1;
                state     <= ISSUE;
              end else begin
                error    <= 1'b1;
                err_addr <= tbl_addr;
                busy     <= 1'b0;
                state    <= ERROR;
              end
            end
`ifdef AIC3204_CFG_READBACK_EN
            // A completed WRITE is followed by a read of the same register;
            // the read's retry budget starts fresh.
            else if (is_write && !rw_q) begin
              rw_q      <= 1'b1;
              retry     <= '0;
              cmd_valid <= 1'b1;
              state     <= ISSUE;
            end else if (rw_q && (rsp_rdata != cmd_wdata)) begin
              error    <= 1'b1;
              err_addr <= tbl_addr;
              busy     <= 1'b0;
              state    <= ERROR;
            end
`endif
            else if (last_entry) begin
              error    <= 1'b1;
              err_addr <= 8'hFF;
              busy     <= 1'b0;
              state    <= ERROR;
            end else begin
              tbl_addr <= tbl_addr + 8'd1;
              retry    <= '0;
              state    <= FETCH;
            end
          end
        end
        DELAY: begin
          // A zero count still spends exactly one cycle here.
          if (dly_cnt > CNT_W'(1)) begin
            dly_cnt <= dly_cnt - CNT_W'(1);
          end else if (last_entry) begin
            error    <= 1'b1;
            err_addr <= 8'hFF;
            busy     <= 1'b0;
            state    <= ERROR;
          end else begin
            tbl_addr <= tbl_addr + 8'd1;
            retry    <= '0;
            state    <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aic3204_cfg_seq.sv
// tb/tb_aic3204_cfg_seq.sv - randomized bench for aic3204_cfg_seq against a table-walk model
// Read-back scenarios are exercised when AIC3204_CFG_READBACK_EN is defined.
module tb_aic3204_cfg_seq;
  localparam int DU = 10;
  localparam int MR = 3;
  localparam logic [17:0] END_E = 18'h30000;
`ifdef AIC3204_CFG_READBACK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif

  logic clk = 1'b0;
  logic reset, start, cmd_ready, rsp_valid, rsp_nack;
  logic [7:0] tbl_addr, cmd_reg, cmd_wdata, rsp_rdata, err_addr;
  logic [17:0] tbl_data;
  logic cmd_valid, cmd_rw, busy, done, error;

  aic3204_cfg_seq #(.DELAY_UNIT(DU), .MAX_RETRY(MR)) dut (
    .clk(clk), .reset(reset), .start(start), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw), .cmd_reg(cmd_reg),
    .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_nack(rsp_nack), .rsp_rdata(rsp_rdata),
    .busy(busy), .done(done), .error(error), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rw;
    logic [7:0] rg;
    logic [7:0] wd;
    logic       nack;
    logic [7:0] rdata;
  } cmd_t;

  logic [17:0] mem [256];
  int          nk_w [256];
  int          nk_r [256];
  bit          rb_bad [256];
  cmd_t        exp_q [$];
  int          acc_cyc [$];
  bit          exp_done, exp_err;
  logic [7:0]  exp_err_addr;
  int n_cmp = 0, n_err = 0, n_acc = 0, n_exp = 0, stall_seen = 0, cyc = 0;
  int ready_mode = 0, rsp_lat = 3, stall_n = 5;
  bit lat_rand = 0, spur_en = 0, flush = 1, outstanding = 0;

  always @(posedge clk) begin
    tbl_data <= mem[tbl_addr];
    cyc      <= cyc + 1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void clear_plan();
    for (int a = 0; a < 256; a++) begin
      mem[a] = END_E; nk_w[a] = 0; nk_r[a] = 0; rb_bad[a] = 0;
    end
  endfunction

  // n NACKed attempts then one ACK, capped at MR re-issues; returns whether it succeeds
  function automatic bit push_cmd(input logic rw, input logic [7:0] rg, input logic [7:0] wd,
                                  input int n, input logic [7:0] rd);
    cmd_t c;
    for (int i = 0; i <= n && i <= MR; i++) begin
      c.rw = rw; c.rg = rg; c.wd = wd; c.nack = (i < n); c.rdata = rd;
      exp_q.push_back(c);
    end
    return n <= MR;
  endfunction

  function automatic void build_model();
    int a = 0;
    bit fin = 0, ok;
    logic [17:0] e;
    logic [7:0] rg;
    exp_q.delete(); exp_done = 0; exp_err = 0; exp_err_addr = 0;
    while (!fin) begin
      e = mem[a]; ok = 1;
      case (e[17:16])
        2'b11: begin exp_done = 1; fin = 1; end
        2'b01: ok = 1;
        default: begin
          rg = (e[17:16] == 2'b10) ? 8'h00 : e[15:8];
          ok = push_cmd(1'b0, rg, e[7:0], nk_w[a], 8'h00);
          if (RB == 1 && ok && e[17:16] == 2'b00) begin
            ok = push_cmd(1'b1, rg, e[7:0], nk_r[a], rb_bad[a] ? (e[7:0] ^ 8'h01) : e[7:0]);
            if (rb_bad[a]) ok = 0;
          end
        end
      endcase
      if (!fin) begin
        if (!ok || a == 255) begin exp_err = 1; exp_err_addr = 8'(a); fin = 1; end
        else a++;
      end
    end
  endfunction

  // I2C engine responder plus the per-cycle compare process
  initial begin : engine
    cmd_t c;
    bit hold = 0;
    logic [16:0] held = '0;
    int rsp_cd = 0, stall_left = 0;
    logic p_nack = 0;
    logic [7:0] p_rdata = 0;
    cmd_ready = 0; rsp_valid = 0; rsp_nack = 0; rsp_rdata = 0;
    forever begin
      @(negedge clk);
      rsp_valid = 0; rsp_nack = 0; rsp_rdata = 0;
      if (flush || reset) begin
        outstanding = 0; hold = 0; stall_left = stall_n; cmd_ready = (ready_mode == 0);
      end else begin
        chk("inv_done_error", done && error, 0);
        chk("inv_busy_status", busy && (done || error), 0);
        chk("inv_valid_busy", cmd_valid && !busy, 0);
        if (hold && cmd_valid) chk("cmd_hold_stable", {cmd_rw, cmd_reg, cmd_wdata}, held);
        if (outstanding) begin
          rsp_cd--;
          if (rsp_cd <= 0) begin
            rsp_valid = 1; rsp_nack = p_nack; rsp_rdata = p_rdata; outstanding = 0;
          end
        end else if (cmd_valid) begin
          case (ready_mode)
            0: cmd_ready = 1;
            1: cmd_ready = 1'($urandom_range(0, 1));
            default: cmd_ready = (stall_left == 0);
          endcase
          if (!cmd_ready) begin
            stall_seen++;
            if (stall_left > 0) stall_left--;
          end else begin
            chk("cmd_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
              c = exp_q.pop_front();
              chk("cmd_rw", cmd_rw, c.rw);
              chk("cmd_reg", cmd_reg, c.rg);
              if (!c.rw) chk("cmd_wdata", cmd_wdata, c.wd);
              p_nack = c.nack; p_rdata = c.rdata;
            end else begin
              p_nack = 0; p_rdata = 0;
            end
            acc_cyc.push_back(cyc);
            n_acc++;
            outstanding = 1;
            rsp_cd = lat_rand ? int'($urandom_range(1, 4)) : rsp_lat;
            stall_left = stall_n;
          end
        end else begin
          cmd_ready = (ready_mode == 0);
          if (spur_en && $urandom_range(0, 7) == 0) begin
            rsp_valid = 1; rsp_nack = 1'($urandom_range(0, 1)); rsp_rdata = 8'($urandom);
          end
        end
        hold = cmd_valid && !cmd_ready;
        held = {cmd_rw, cmd_reg, cmd_wdata};
      end
    end
  end

  task automatic do_reset();
    reset = 1; flush = 1;
    repeat (2) @(negedge clk);
    reset = 0; exp_q.delete(); flush = 0;
  endtask

  task automatic run_table(input string nm, input int budget, input bit rst_first);
    int t = 0;
    if (rst_first) do_reset();
    build_model();
    n_exp = exp_q.size(); n_acc = 0; stall_seen = 0; acc_cyc.delete();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    while (!(done || error) && t < budget) begin @(negedge clk); t++; end
    chk({nm, "_in_time"}, t < budget, 1);
    chk({nm, "_done"}, done, exp_done);
    chk({nm, "_error"}, error, exp_err);
    chk({nm, "_err_addr"}, err_addr, exp_err ? exp_err_addr : 8'h00);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_accepts"}, n_acc, n_exp);
    if (t >= budget) do_reset();
  endtask

  initial begin : main
    int g0, t, v, r, n;
    reset = 1; start = 0;
    clear_plan();
    repeat (3) @(negedge clk);
    chk("reset_outputs", {tbl_addr, cmd_valid, cmd_rw, cmd_reg, cmd_wdata, busy, done, error, err_addr}, 0);
    reset = 0; flush = 0;

    mem[0] = {2'b10, 8'h00, 8'h00}; mem[1] = {2'b00, 8'h01, 8'h01}; mem[2] = END_E;
    build_model();
    chk("model_basic_len", exp_q.size(), 2 + RB);
    chk("model_basic_cmd0", {exp_q[0].rg, exp_q[0].wd}, 16'h0000);
    chk("model_basic_cmd1", {exp_q[1].rg, exp_q[1].wd}, 16'h0101);
    run_table("basic", 2000, 0);
    chk("basic_done_lit", {done, busy}, 2'b10);

    clear_plan();
    mem[0] = {2'b10, 8'h00, 8'h11}; mem[1] = {2'b10, 8'h00, 8'h22};
    run_table("gap_base", 2000, 0);
    g0 = acc_cyc.size() >= 2 ? acc_cyc[1] - acc_cyc[0] : 0;
    for (int k = 0; k < 2; k++) begin
      v = (k == 0) ? 2 : 0;
      clear_plan();
      mem[0] = {2'b10, 8'h00, 8'h11}; mem[1] = {2'b01, 8'h00, 8'(v)}; mem[2] = {2'b10, 8'h00, 8'h22};
      run_table("gap_delay", 2000, 0);
      // delay entry costs its own fetch/decode plus max(1, v*DU) cycles in DELAY
      chk("delay_gap", acc_cyc.size() >= 2 ? acc_cyc[1] - acc_cyc[0] - g0 : -1,
          2 + ((v * DU == 0) ? 1 : v * DU));
    end

    clear_plan(); ready_mode = 2;
    mem[0] = {2'b00, 8'h10, 8'h22};
    run_table("stall", 2000, 0);
    chk("stall_cycles", stall_seen, 5 * (1 + RB));
    chk("stall_one_accept", n_acc, 1 + RB);
    ready_mode = 0;

    clear_plan();
    mem[0] = {2'b10, 8'h00, 8'h00}; mem[1] = {2'b00, 8'h20, 8'h33}; nk_w[1] = 4;
    build_model();
    chk("model_nack4", {exp_err, exp_err_addr, 8'(exp_q.size())}, {1'b1, 8'h01, 8'h05});
    run_table("nack4", 2000, 0);
    chk("nack4_issues", n_acc, 5);
    nk_w[1] = 2;
    run_table("nack2", 2000, 0);
    chk("nack2_done_lit", {done, error}, 2'b10);

    clear_plan(); rsp_lat = 20;
    for (int a = 0; a < 3; a++) mem[a] = {2'b00, 8'(a + 3), 8'(a + 40)};
    build_model();
    @(negedge clk); start = 1; @(negedge clk); start = 0;
    t = 0;
    while (!outstanding && t < 200) begin @(negedge clk); t++; end
    chk("reach_wait_rsp", t < 200, 1);
    reset = 1; flush = 1; @(negedge clk);
    chk("reset_wait_rsp_outs", {tbl_addr, cmd_valid, cmd_rw, cmd_reg, cmd_wdata, busy, done, error, err_addr}, 0);
    @(negedge clk); reset = 0; flush = 0; exp_q.delete();
    rsp_lat = 3; ready_mode = 2; stall_n = 20;
    build_model();
    @(negedge clk); start = 1; @(negedge clk); start = 0;
    t = 0;
    while (!cmd_valid && t < 200) begin @(negedge clk); t++; end
    chk("reach_issue", t < 200, 1);
    reset = 1; flush = 1; @(negedge clk);
    chk("reset_issue_valid", {cmd_valid, busy}, 0);
    @(negedge clk); reset = 0; flush = 0; exp_q.delete();
    ready_mode = 0; stall_n = 5;
    run_table("rerun", 2000, 0);

`ifdef AIC3204_CFG_READBACK_EN
    clear_plan();
    mem[0] = {2'b00, 8'h05, 8'h91}; rb_bad[0] = 1;
    run_table("rb_bad", 2000, 0);
    chk("rb_bad_lit", {error, err_addr}, {1'b1, 8'h00});
    rb_bad[0] = 0;
    run_table("rb_good", 2000, 0);
    chk("rb_good_lit", done, 1);
`endif

    clear_plan();
    for (int a = 0; a < 256; a++) mem[a] = (a % 16 == 5) ? {2'b10, 8'h00, 8'(a)} : 18'h10000;
    build_model();
    chk("model_no_end", {exp_err, exp_err_addr}, {1'b1, 8'hFF});
    run_table("no_end", 6000, 0);
    chk("no_end_addr", tbl_addr, 8'hFF);

    for (int it = 0; it < 25; it++) begin
      clear_plan();
      n = $urandom_range(1, 10);
      for (int a = 0; a < n; a++) begin
        r = $urandom_range(0, 9);
        if (r < 5)      mem[a] = {2'b00, 8'($urandom), 8'($urandom)};
        else if (r < 8) mem[a] = {2'b10, 8'($urandom), 8'($urandom)};
        else            mem[a] = {2'b01, 8'($urandom), 8'($urandom_range(0, 3))};
        r = $urandom_range(0, 9);
        nk_w[a] = (r < 6) ? 0 : (r < 8) ? int'($urandom_range(1, 2)) : (r == 8) ? 3 : 4;
        nk_r[a] = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 4)) : 0;
        rb_bad[a] = ($urandom_range(0, 7) == 0);
      end
      ready_mode = $urandom_range(0, 1); lat_rand = 1; spur_en = 1;
      run_table("rand", 5000, it % 3 == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/aic3204_cfg_seq.md
AIC3204_CFG_SEQ -- requirements
Module: aic3204_cfg_seq

Interface
REQ-001 Parameter DELAY_UNIT, default 100000, clk cycles per delay tick (1 ms at 100 MHz).
REQ-002 Parameter MAX_RETRY, default 3, number of re-issues of a NACKed command before the block enters ERROR.
REQ-003 clk  in  1  single clock for all logic.
REQ-004 reset  in  1  reset; synchronous, active-high.
REQ-005 start  in  1  one-cycle pulse that starts the sequence from table entry 0.
REQ-006 tbl_addr  out  8  table entry address.
REQ-007 tbl_data  in  18  table entry, available one cycle after tbl_addr; [17:16] opcode, [15:8] reg, [7:0] value.
REQ-008 cmd_valid / cmd_ready  out / in  1 / 1  command handshake to the I2C byte engine.
REQ-009 cmd_rw  out  1  command direction; 0 = write, 1 = read.
REQ-010 cmd_reg, cmd_wdata  out  8 each  codec register address and write data.
REQ-011 rsp_valid, rsp_nack  in  1 each  one-cycle command completion pulse and its NACK flag.
REQ-012 rsp_rdata  in  8  read data, valid with rsp_valid.
REQ-013 busy, done, error  out  1 each  sequence status.
REQ-014 err_addr  out  8  address of the table entry that failed.

Function
REQ-015 FSM states: IDLE, FETCH, DECODE, ISSUE, WAIT_RSP, DELAY, DONE, ERROR.
REQ-016 IDLE/DONE/ERROR + start -> FETCH; clear tbl_addr, done, error, err_addr and the retry count.
REQ-017 FETCH drives tbl_addr and goes to DECODE after one cycle; DECODE registers tbl_data.
REQ-018 Opcode 00 (WRITE): go to ISSUE with cmd_rw=0, cmd_reg=reg, cmd_wdata=value.
REQ-019 Opcode 10 (PAGE): go to ISSUE with cmd_rw=0, cmd_reg=0x00, cmd_wdata=value.
REQ-020 Opcode 01 (DELAY): go to DELAY and stay value*DELAY_UNIT cycles; value 0 gives zero wait, so DELAY exits on its first cycle.
REQ-021 Opcode 11 (END): go to DONE; done=1 and busy=0 and both hold until the next start.
REQ-022 ISSUE: cmd_valid=1, with cmd_* held stable until the cycle where cmd_valid&&cmd_ready; then go to WAIT_RSP with cmd_valid=0 in the next cycle.
REQ-023 WAIT_RSP, rsp_valid with rsp_nack=0: increment tbl_addr, clear the retry count, go to FETCH.
REQ-024 WAIT_RSP, rsp_valid with rsp_nack=1: if retry count < MAX_RETRY, increment it and re-enter ISSUE; otherwise go to ERROR.
REQ-025 ERROR: error=1 and err_addr=tbl_addr; hold until start.
REQ-026 tbl_addr reaching 255 without an END entry: after entry 255 completes, go to ERROR with err_addr=255; tbl_addr does not wrap.
REQ-027 busy=1 in every state except IDLE, DONE and ERROR.
REQ-028 start while busy is ignored.
REQ-029 rsp_valid outside WAIT_RSP is ignored.
REQ-030 The delay counter is sized to hold 255*DELAY_UNIT.

Reset
REQ-031 While reset=1 at a clk edge, the FSM goes to IDLE and all outputs go to 0, including tbl_addr, cmd_*, busy, done, error and err_addr.
REQ-032 Reset mid-transaction (including while cmd_valid=1) drops cmd_valid in the next cycle; the block then waits for a new start.

Configuration
REQ-033 Macro AIC3204_CFG_READBACK_EN is defined: after each successful WRITE (not PAGE), the block issues a read (cmd_rw=1) of the same reg; rsp_rdata != value goes to ERROR without retry, and a NACK on the read uses the REQ-024 retry rule.
REQ-034 Macro AIC3204_CFG_READBACK_EN is undefined: there is no read-back and cmd_rw is tied 0.

Verification
REQ-035 Table {PAGE 0x00, WRITE 0x01=0x01, END}, cmd_ready=1, rsp_valid 3 cycles after accept -> two commands (0x00/0x00, 0x01/0x01); then done=1, busy=0.
REQ-036 DELAY value 2 with DELAY_UNIT=10 -> 20 cycles with no cmd_valid between the neighbouring commands.
REQ-037 cmd_ready low for 5 cycles -> cmd_valid and cmd_* stay stable for those cycles; exactly one accept.
REQ-038 WRITE NACKed 4 times with MAX_RETRY=3 -> 4 issues, then error=1 and err_addr equals that entry index; NACKed 2 times -> sequence completes with done=1.
REQ-039 Reset asserted while in WAIT_RSP -> all outputs 0; a later start reruns from entry 0.
REQ-040 With AIC3204_CFG_READBACK_EN: WRITE 0x05=0x91 and read returns 0x90 -> error=1 and err_addr equals that entry; read returns 0x91 -> sequence proceeds.
